// File: rtl/operand_fetcher.sv
`timescale 1ns/1ps
// operand_fetcher
//   Fetches 0..3 little-endian operand bytes at pc. For indirect modes it
//   then fetches a 2- or 3-byte pointer. From these it computes the
//   effective address for the requested addressing mode.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 begin a fetch (accepted only while idle)
//   mode[3:0]             addressing mode, encoded as mode_t below
//   extra_bytes[2:0]      operand byte count 0..3 (larger values clamp to 3)
//   pc, dp, sp            operand address, direct-page base, stack pointer
//   index_x, index_y      index registers
//   mem_addr, mem_rd      read request; address holds until mem_ready
//   mem_data_in, mem_ready  read data / read completion
//   operand[23:0]         raw operand bytes, zero-extended
//   ea                    effective address
//   ea_valid              one-cycle completion pulse
//   busy                  high from accepted start until ea_valid
//   bad_mode              pulses with ea_valid for unsupported modes
//
// Build option
//   INDIRECT_24_EN        enables the 24-bit pointer modes INDIRECT_24 and
//                         INDIRECT_24_Y. Without it those modes complete
//                         with ea=0 and bad_mode, and no pointer read occurs.
module operand_fetcher #(
  parameter int unsigned ADDR_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        mode,
  input  logic [2:0]        extra_bytes,
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       dp,
  input  logic [ADDR_W-1:0] sp,
  input  logic [ADDR_W-1:0] index_x,
  input  logic [ADDR_W-1:0] index_y,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data_in,
  input  logic              mem_ready,
  output logic [23:0]       operand,
  output logic [ADDR_W-1:0] ea,
  output logic              ea_valid,
  output logic              busy,
  output logic              bad_mode
);

  typedef enum logic [2:0] {
    S_IDLE, S_OPERAND, S_POINTER, S_CALC, S_DONE
  } state_t;

  typedef enum logic [3:0] {
    MODE_NONE           = 4'd0,
    MODE_A              = 4'd1,
    MODE_IMMEDIATE      = 4'd2,
    MODE_ZP             = 4'd3,
    MODE_INDEXED_X      = 4'd4,
    MODE_ABSOLUTE       = 4'd5,
    MODE_ABSOLUTE_X     = 4'd6,
    MODE_ABSOLUTE_Y     = 4'd7,
    MODE_STACK_RELATIVE = 4'd8,
    MODE_INDIRECT_X     = 4'd9,
    MODE_INDIRECT_Y     = 4'd10,
    MODE_INDIRECT_S_Y   = 4'd11,
    MODE_INDIRECT_24    = 4'd12,
    MODE_INDIRECT_24_Y  = 4'd13
  } mode_t;

  state_t state, state_next;

  logic [3:0]        mode_q;
  logic [1:0]        nbytes_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] pc_q, sp_q, x_q, y_q;
  logic [15:0]       dp_q;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       operand_q;
  logic [23:0]       ptr_q;
  logic [ADDR_W-1:0] ea_q;
  logic              bad_q;

  logic              ptr_mode;
  logic [1:0]        ptr_len;
  logic              unsupported;
  logic [23:0]       operand_new;
  logic [23:0]       ptr_new;
  logic [ADDR_W-1:0] off8, base8, ptr_addr, ea_calc;
  logic              last_operand, last_ptr;

  always_comb begin
    ptr_mode    = 1'b0;
    ptr_len     = 2'd2;
    unsupported = 1'b0;
    case (mode_q)
      MODE_INDIRECT_X, MODE_INDIRECT_Y, MODE_INDIRECT_S_Y: ptr_mode = 1'b1;
      MODE_INDIRECT_24, MODE_INDIRECT_24_Y: begin
`ifdef INDIRECT_24_EN
        ptr_mode = 1'b1;
        ptr_len  = 2'd3;
`else
        unsupported = 1'b1;
`endif
      end
      MODE_NONE, MODE_A, MODE_IMMEDIATE, MODE_ZP, MODE_INDEXED_X,
      MODE_ABSOLUTE, MODE_ABSOLUTE_X, MODE_ABSOLUTE_Y,
      MODE_STACK_RELATIVE: ;
      default: unsupported = 1'b1;
    endcase
  end

  // operand/pointer with the byte completing this cycle merged in, so the
  // pointer address can be formed on the same edge as the last operand byte.
  always_comb begin
    operand_new = operand_q;
    if (state == S_OPERAND && mem_ready) begin
      case (cnt_q)
        2'd0:    operand_new[7:0]   = mem_data_in;
        2'd1:    operand_new[15:8]  = mem_data_in;
        default: operand_new[23:16] = mem_data_in;
      endcase
    end
  end

  always_comb begin
    ptr_new = ptr_q;
    if (state == S_POINTER && mem_ready) begin
      case (cnt_q)
        2'd0:    ptr_new[7:0]   = mem_data_in;
        2'd1:    ptr_new[15:8]  = mem_data_in;
        default: ptr_new[23:16] = mem_data_in;
      endcase
    end
  end

  assign off8  = ADDR_W'(operand_new[7:0]);
  assign base8 = ADDR_W'(dp_q) + off8;

  always_comb begin
    case (mode_q)
      MODE_INDIRECT_X:   ptr_addr = base8 + x_q;
      MODE_INDIRECT_S_Y: ptr_addr = sp_q + off8;
      default:           ptr_addr = base8;
    endcase
  end

  always_comb begin
    ea_calc = '0;
    case (mode_q)
      MODE_IMMEDIATE:      ea_calc = pc_q;
      MODE_ZP:             ea_calc = base8;
      MODE_INDEXED_X:      ea_calc = base8 + x_q;
      MODE_ABSOLUTE:       ea_calc = ADDR_W'(operand_q);
      MODE_ABSOLUTE_X:     ea_calc = ADDR_W'(operand_q) + x_q;
      MODE_ABSOLUTE_Y:     ea_calc = ADDR_W'(operand_q) + y_q;
      MODE_STACK_RELATIVE: ea_calc = sp_q + off8;
      MODE_INDIRECT_X:     ea_calc = ADDR_W'(ptr_q);
      MODE_INDIRECT_Y,
      MODE_INDIRECT_S_Y:   ea_calc = ADDR_W'(ptr_q) + y_q;
`ifdef INDIRECT_24_EN
      MODE_INDIRECT_24:    ea_calc = ADDR_W'(ptr_q);
      MODE_INDIRECT_24_Y:  ea_calc = ADDR_W'(ptr_q) + y_q;
`endif
      default:             ea_calc = '0;
    endcase
  end

  assign last_operand = (state == S_OPERAND) && mem_ready &&
                        (cnt_q == nbytes_q - 2'd1);
  assign last_ptr     = (state == S_POINTER) && mem_ready &&
                        (cnt_q == ptr_len - 2'd1);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = (extra_bytes == 3'd0) ? S_CALC : S_OPERAND;
      S_OPERAND: if (last_operand) state_next = ptr_mode ? S_POINTER : S_CALC;
      S_POINTER: if (last_ptr) state_next = S_CALC;
      S_CALC:    state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mode_q    <= '0;
      nbytes_q  <= '0;
      cnt_q     <= '0;
      pc_q      <= '0;
      dp_q      <= '0;
      sp_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      operand_q <= '0;
      ptr_q     <= '0;
      ea_q      <= '0;
      bad_q     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q    <= mode;
            nbytes_q  <= (extra_bytes > 3'd3) ? 2'd3 : extra_bytes[1:0];
            pc_q      <= pc;
            dp_q      <= dp;
            sp_q      <= sp;
            x_q       <= index_x;
            y_q       <= index_y;
            addr_q    <= pc;
            cnt_q     <= '0;
            operand_q <= '0;
            ptr_q     <= '0;
            bad_q     <= 1'b0;
          end
        end
        S_OPERAND: begin
          if (mem_ready) begin
            operand_q <= operand_new;
            if (last_operand) begin
              cnt_q <= '0;
              if (ptr_mode) addr_q <= ptr_addr;
            end else begin
              cnt_q  <= cnt_q + 2'd1;
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        S_POINTER: begin
          if (mem_ready) begin
            ptr_q  <= ptr_new;
            cnt_q  <= cnt_q + 2'd1;
            addr_q <= addr_q + 1'b1;
          end
        end
        S_CALC: begin
          ea_q  <= ea_calc;
          bad_q <= unsupported;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr = addr_q;
  assign mem_rd   = (state == S_OPERAND) || (state == S_POINTER);
  assign operand  = operand_q;
  assign ea       = ea_q;
  assign ea_valid = (state == S_DONE);
  assign busy     = (state != S_IDLE);
  assign bad_mode = ea_valid && bad_q;

endmodule

// File: tb/tb_operand_fetcher.sv
`timescale 1ns/1ps
// Scoreboard bench for operand_fetcher: stimulus pushes expected results
// and expected read addresses; negedge monitors pop and compare.
module tb_operand_fetcher;

  localparam logic [3:0] M_NONE   = 4'd0;
  localparam logic [3:0] M_IMM    = 4'd2;
  localparam logic [3:0] M_ZP     = 4'd3;
  localparam logic [3:0] M_IDXX   = 4'd4;
  localparam logic [3:0] M_ABS    = 4'd5;
  localparam logic [3:0] M_ABSX   = 4'd6;
  localparam logic [3:0] M_ABSY   = 4'd7;
  localparam logic [3:0] M_STK    = 4'd8;
  localparam logic [3:0] M_INDX   = 4'd9;
  localparam logic [3:0] M_INDY   = 4'd10;
  localparam logic [3:0] M_INDSY  = 4'd11;
  localparam logic [3:0] M_IND24  = 4'd12;

  logic        clk = 1'b0;
  logic        reset, start, mem_rd, mem_ready, ea_valid, busy, bad_mode;
  logic [3:0]  mode;
  logic [2:0]  extra_bytes;
  logic [23:0] pc, sp, index_x, index_y, mem_addr, ea, operand;
  logic [15:0] dp;
  logic [7:0]  mem_data_in;

  always #5 clk = ~clk;

  operand_fetcher #(.ADDR_W(24)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .extra_bytes(extra_bytes), .pc(pc), .dp(dp), .sp(sp),
    .index_x(index_x), .index_y(index_y), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_data_in(mem_data_in), .mem_ready(mem_ready),
    .operand(operand), .ea(ea), .ea_valid(ea_valid), .busy(busy),
    .bad_mode(bad_mode)
  );

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] ea;
    logic [23:0] op;
    logic        bad;
    int unsigned at;
  } exp_t;
  exp_t        exp_q[$];
  logic [23:0] rd_q[$];

  logic [23:0] tab_a[8];
  logic [7:0]  tab_d[8];
  logic        tab_v[8];

  always_comb begin
    mem_data_in = 8'h00;
    for (int i = 0; i < 8; i++)
      if (tab_v[i] && tab_a[i] == mem_addr) mem_data_in = tab_d[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Completed reads and completion pulses.
  always @(negedge clk) begin
    exp_t e;
    if (mem_rd === 1'b1 && mem_ready === 1'b1) begin
      if (rd_q.size() == 0) fail_now("rd_unexpected");
      else check("rd_addr", {8'h0, mem_addr}, {8'h0, rd_q.pop_front()});
    end
    if (ea_valid === 1'b1) begin
      if (exp_q.size() == 0) fail_now("ea_valid_unexpected");
      else begin
        e = exp_q.pop_front();
        check("ea", {8'h0, ea}, {8'h0, e.ea});
        check("operand", {8'h0, operand}, {8'h0, e.op});
        check("bad_mode", {31'h0, bad_mode}, {31'h0, e.bad});
        check("latency", cyc, e.at);
      end
    end
    if (bad_mode === 1'b1 && ea_valid !== 1'b1) fail_now("bad_mode_without_ea_valid");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 8; i++) begin
      tab_v[i] = 1'b0;
      tab_a[i] = '0;
      tab_d[i] = '0;
    end
  endtask

  task automatic put(input int i, input logic [23:0] a, input logic [7:0] d);
    tab_a[i] = a;
    tab_d[i] = d;
    tab_v[i] = 1'b1;
  endtask

  task automatic setup(input logic [3:0] m, input logic [2:0] eb, input logic [23:0] p,
                       input logic [15:0] d, input logic [23:0] s,
                       input logic [23:0] x, input logic [23:0] y);
    mode = m; extra_bytes = eb; pc = p; dp = d; sp = s; index_x = x; index_y = y;
  endtask

  task automatic exp_rd(input logic [23:0] a);
    rd_q.push_back(a);
  endtask

  task automatic go(input logic [23:0] e_ea, input logic [23:0] e_op,
                    input logic e_bad, input int unsigned lat);
    exp_t e;
    e.ea = e_ea; e.op = e_op; e.bad = e_bad; e.at = cyc + lat;
    exp_q.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done;
    int n = 0;
    while (busy === 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) fail_now("timeout_busy");
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; mem_ready = 1'b1;
    setup(M_NONE, 3'd0, '0, '0, '0, '0, '0);
    clear_mem();
    tick(); tick(); tick();
    check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
    check("rst_mem_addr", {8'h0, mem_addr}, 32'h0);
    check("rst_operand", {8'h0, operand}, 32'h0);
    check("rst_ea", {8'h0, ea}, 32'h0);
    check("rst_ea_valid", {31'h0, ea_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_bad_mode", {31'h0, bad_mode}, 32'h0);
    reset = 1'b0;
    tick();

    // ABSOLUTE_X, two bytes
    clear_mem(); put(0, 24'h001000, 8'h34); put(1, 24'h001001, 8'h12);
    setup(M_ABSX, 3'd2, 24'h001000, 16'h0000, 24'h0, 24'h000010, 24'h0);
    exp_rd(24'h001000); exp_rd(24'h001001);
    go(24'h001244, 24'h001234, 1'b0, 4);
    check("busy_during", {31'h0, busy}, 32'h1);
    wait_done();

    // INDIRECT_Y
    clear_mem(); put(0, 24'h002000, 8'h10); put(1, 24'h000210, 8'h00); put(2, 24'h000211, 8'h80);
    setup(M_INDY, 3'd1, 24'h002000, 16'h0200, 24'h0, 24'h0, 24'h000005);
    exp_rd(24'h002000); exp_rd(24'h000210); exp_rd(24'h000211);
    go(24'h008005, 24'h000010, 1'b0, 5);
    wait_done();

    // ABSOLUTE_Y wrap
    clear_mem(); put(0, 24'h003000, 8'hFF); put(1, 24'h003001, 8'hFF); put(2, 24'h003002, 8'hFF);
    setup(M_ABSY, 3'd3, 24'h003000, 16'h0, 24'h0, 24'h0, 24'h000002);
    exp_rd(24'h003000); exp_rd(24'h003001); exp_rd(24'h003002);
    go(24'h000001, 24'hFFFFFF, 1'b0, 5);
    wait_done();

    // ZP with three wait cycles on the first read
    clear_mem(); put(0, 24'h004000, 8'h10);
    setup(M_ZP, 3'd1, 24'h004000, 16'h0200, 24'h0, 24'h0, 24'h0);
    exp_rd(24'h004000);
    mem_ready = 1'b0;
    go(24'h000210, 24'h000010, 1'b0, 6);
    for (int k = 0; k < 3; k++) begin
      check("stall_mem_rd", {31'h0, mem_rd}, 32'h1);
      check("stall_mem_addr", {8'h0, mem_addr}, 32'h004000);
      tick();
    end
    mem_ready = 1'b1;
    wait_done();

    // INDEXED_X
    clear_mem(); put(0, 24'h005000, 8'h20);
    setup(M_IDXX, 3'd1, 24'h005000, 16'h00F0, 24'h0, 24'h000005, 24'h0);
    exp_rd(24'h005000);
    go(24'h000115, 24'h000020, 1'b0, 3);
    wait_done();

    // STACK_RELATIVE
    clear_mem(); put(0, 24'h005100, 8'h03);
    setup(M_STK, 3'd1, 24'h005100, 16'h0, 24'h0001FF, 24'h0, 24'h0);
    exp_rd(24'h005100);
    go(24'h000202, 24'h000003, 1'b0, 3);
    wait_done();

    // INDIRECT_X
    clear_mem(); put(0, 24'h005200, 8'h08); put(1, 24'h00010C, 8'hCD); put(2, 24'h00010D, 8'hAB);
    setup(M_INDX, 3'd1, 24'h005200, 16'h0100, 24'h0, 24'h000004, 24'h0);
    exp_rd(24'h005200); exp_rd(24'h00010C); exp_rd(24'h00010D);
    go(24'h00ABCD, 24'h000008, 1'b0, 5);
    wait_done();

    // INDIRECT_S_Y
    clear_mem(); put(0, 24'h005300, 8'h02); put(1, 24'h0001F2, 8'h00); put(2, 24'h0001F3, 8'h90);
    setup(M_INDSY, 3'd1, 24'h005300, 16'h0, 24'h0001F0, 24'h0, 24'h000010);
    exp_rd(24'h005300); exp_rd(24'h0001F2); exp_rd(24'h0001F3);
    go(24'h009010, 24'h000002, 1'b0, 5);
    wait_done();

    // ABSOLUTE
    clear_mem(); put(0, 24'h005400, 8'h78); put(1, 24'h005401, 8'h56);
    setup(M_ABS, 3'd2, 24'h005400, 16'h0, 24'h0, 24'h0, 24'h0);
    exp_rd(24'h005400); exp_rd(24'h005401);
    go(24'h005678, 24'h005678, 1'b0, 4);
    wait_done();

    // IMMEDIATE, one byte
    clear_mem(); put(0, 24'h005500, 8'hAA);
    setup(M_IMM, 3'd1, 24'h005500, 16'h0, 24'h0, 24'h0, 24'h0);
    exp_rd(24'h005500);
    go(24'h005500, 24'h0000AA, 1'b0, 3);
    wait_done();

    // INDIRECT_24
    clear_mem(); put(0, 24'h005600, 8'h40);
    put(1, 24'h000040, 8'h56); put(2, 24'h000041, 8'h34); put(3, 24'h000042, 8'h12);
    setup(M_IND24, 3'd1, 24'h005600, 16'h0, 24'h0, 24'h0, 24'h0);
    exp_rd(24'h005600);
`ifdef INDIRECT_24_EN
    exp_rd(24'h000040); exp_rd(24'h000041); exp_rd(24'h000042);
    go(24'h123456, 24'h000040, 1'b0, 6);
`else
    go(24'h000000, 24'h000040, 1'b1, 3);
`endif
    wait_done();

    // NONE, no operand bytes
    clear_mem();
    setup(M_NONE, 3'd0, 24'h005700, 16'h0, 24'h0, 24'h0, 24'h0);
    go(24'h000000, 24'h000000, 1'b0, 2);
    wait_done();

    // Reset while in POINTER, then a normal fetch
    clear_mem(); put(0, 24'h006000, 8'h10); put(1, 24'h000210, 8'h00); put(2, 24'h000211, 8'h80);
    setup(M_INDY, 3'd1, 24'h006000, 16'h0200, 24'h0, 24'h0, 24'h000005);
    exp_rd(24'h006000); exp_rd(24'h000210);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("ptr_mem_rd", {31'h0, mem_rd}, 32'h1);
    check("ptr_mem_addr", {8'h0, mem_addr}, 32'h000210);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_mem_rd", {31'h0, mem_rd}, 32'h0);
    exp_rd(24'h006000); exp_rd(24'h000210); exp_rd(24'h000211);
    go(24'h008005, 24'h000010, 1'b0, 5);
    wait_done();

    // start held during the ea_valid cycle is ignored
    clear_mem();
    setup(M_IMM, 3'd0, 24'h007000, 16'h0, 24'h0, 24'h0, 24'h0);
    go(24'h007000, 24'h000000, 1'b0, 2);
    tick();
    check("done_ea_valid", {31'h0, ea_valid}, 32'h1);
    pc = 24'h007100;
    start = 1'b1;
    tick();
    check("ignored_start_busy", {31'h0, busy}, 32'h0);
    go(24'h007100, 24'h000000, 1'b0, 2);
    wait_done();

    tick(); tick();
    check("exp_queue_drained", exp_q.size(), 32'h0);
    check("rd_queue_drained", rd_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
